// File: rtl/pid_pkg.sv
// Shared types and helpers for the time-multiplexed PID controller.
// saturate() works at a fixed wide width; callers sign-extend into it and truncate the result.
package pid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    MUL,
    SUM,
    WB
  } state_e;

  localparam int SAT_W = 128;

  // Inverted limits resolve to the lower limit.
  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] x,
    input logic signed [SAT_W-1:0] lo,
    input logic signed [SAT_W-1:0] hi
  );
    if (lo > hi)     return lo;
    else if (x > hi) return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

  // Integrator is frozen while the output is pinned against a limit that the error drives toward.
  function automatic logic hold_integ(
    input logic clamped_hi,
    input logic clamped_lo,
    input logic e_pos,
    input logic e_neg
  );
    return (clamped_hi && e_pos) || (clamped_lo && e_neg);
  endfunction

endpackage

// File: rtl/pid_prescaler.sv
// Sweep-rate prescaler: one-cycle tick every i_period+1 cycles while enabled, held at 0 otherwise.
module pid_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_enable,
  input  logic [PRESC_W-1:0] i_period,
  output logic               o_tick
);

  logic [PRESC_W-1:0] r_count;

  assign o_tick = i_enable && (r_count == i_period);

  // NOTE: clocked state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_count <= '0;
    else if (!i_enable || o_tick)  r_count <= '0;
    else                           r_count <= r_count + PRESC_W'(1);
  end

endmodule

// File: rtl/pid_controller_mc.sv
// CH independent PID loops sharing one MAC datapath; each prescaler tick sweeps ERR/MUL/SUM/WB per channel.
// Internal datapath width is sized so that nothing wraps before saturation (WIDE_W must stay <= SAT_W).
module pid_controller_mc
  import pid_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int GAIN_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int CH      = 4,
  parameter int ACC_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 integ_clr,
  input  logic [CH*DATA_W-1:0] setpoint,
  input  logic [CH*DATA_W-1:0] feedback,
  input  logic [GAIN_W-1:0]    Kp,
  input  logic [GAIN_W-1:0]    Ki,
  input  logic [GAIN_W-1:0]    Kd,
  input  logic [PRESC_W-1:0]   clk_prescaler,
  input  logic [DATA_W-1:0]    out_min,
  input  logic [DATA_W-1:0]    out_max,
  output logic [CH*DATA_W-1:0] control_signal,
  output logic [CH-1:0]        ctrl_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam int E_W    = DATA_W + 1;
  localparam int PROD_W = DATA_W + GAIN_W + 3;
  localparam int WIDE_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 3;
  localparam logic signed [SAT_W-1:0] I_MAX = (SAT_W'(1) << (ACC_W - 1)) - SAT_W'(1);
  localparam logic signed [SAT_W-1:0] I_MIN = -I_MAX;

  state_e                    r_state, w_state_nxt;
  logic [CH_W-1:0]           r_ch;
  logic                      w_tick, w_last;

  logic signed [E_W-1:0]     r_e, w_e;
  logic signed [E_W-1:0]     r_e_prev [CH];
  logic signed [ACC_W-1:0]   r_integ  [CH];

  logic signed [WIDE_W-1:0]  w_e_x, w_p, w_d, w_i_sum, w_sum, w_raw;
  logic signed [WIDE_W-1:0]  r_p, r_d;
  logic signed [ACC_W-1:0]   r_i_next;
  logic signed [SAT_W-1:0]   w_raw_x, w_u_sat;
  logic signed [DATA_W-1:0]  r_u;
  logic                      r_hold;

  logic [CH*DATA_W-1:0]      r_ctrl;
  logic [CH-1:0]             r_valid;
  logic                      r_overrun;

  pid_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (enable),
    .i_period (clk_prescaler),
    .o_tick   (w_tick)
  );

  assign w_last = (r_ch == CH_W'(CH - 1));

  // Error for the channel under service; inputs are only looked at during ERR.
  assign w_e = $signed({1'b0, setpoint[r_ch*DATA_W +: DATA_W]})
             - $signed({1'b0, feedback[r_ch*DATA_W +: DATA_W]});

  assign w_e_x   = WIDE_W'(r_e);
  assign w_p     = $signed(WIDE_W'({1'b0, Kp})) * w_e_x;
  assign w_d     = $signed(WIDE_W'({1'b0, Kd})) * (w_e_x - WIDE_W'(r_e_prev[r_ch]));
  assign w_i_sum = WIDE_W'(r_integ[r_ch]) + $signed(WIDE_W'({1'b0, Ki})) * w_e_x;

  assign w_sum   = r_p + WIDE_W'(r_i_next) + r_d;
  assign w_raw   = w_sum >>> FRAC_W;
  assign w_raw_x = SAT_W'(w_raw);
  assign w_u_sat = saturate(w_raw_x, SAT_W'($signed(out_min)), SAT_W'($signed(out_max)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_tick) w_state_nxt = ERR;
      ERR:     w_state_nxt = MUL;
      MUL:     w_state_nxt = SUM;
      SUM:     w_state_nxt = WB;
      WB:      w_state_nxt = w_last ? IDLE : ERR;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch      <= '0;
      r_e       <= '0;
      r_p       <= '0;
      r_d       <= '0;
      r_i_next  <= '0;
      r_u       <= '0;
      r_hold    <= 1'b0;
      r_ctrl    <= '0;
      r_valid   <= '0;
      r_overrun <= 1'b0;
      // NOTE: the per-channel arrays are small register files, so they take the async reset too.
      for (int k = 0; k < CH; k++) begin
        r_integ[k]  <= '0;
        r_e_prev[k] <= '0;
      end
    end else begin
      r_valid <= '0;
      if (w_tick && (r_state != IDLE)) r_overrun <= 1'b1;

      case (r_state)
        IDLE: r_ch <= '0;
        ERR:  r_e  <= w_e;
        MUL: begin
          r_p      <= w_p;
          r_d      <= w_d;
          r_i_next <= ACC_W'(saturate(SAT_W'(w_i_sum), I_MIN, I_MAX));
        end
        SUM: begin
          r_u    <= DATA_W'(w_u_sat);
          r_hold <= hold_integ(w_u_sat < w_raw_x, w_u_sat > w_raw_x,
                               !r_e[E_W-1] && (r_e != '0), r_e[E_W-1]);
        end
        WB: begin
          r_ctrl[r_ch*DATA_W +: DATA_W] <= r_u;
          r_valid[r_ch]                 <= 1'b1;
          r_e_prev[r_ch]                <= r_e;
          if (!r_hold) r_integ[r_ch]    <= r_i_next;
          if (!w_last) r_ch             <= r_ch + CH_W'(1);
        end
        default: ;
      endcase

      // Placed last so a clear overrides the WB update of integ/e_prev; the output write stands.
      if (integ_clr) begin
        for (int k = 0; k < CH; k++) begin
          r_integ[k]  <= '0;
          r_e_prev[k] <= '0;
        end
      end
    end
  end

  assign control_signal = r_ctrl;
  assign ctrl_valid     = r_valid;
  assign busy           = (r_state != IDLE);
  assign overrun        = r_overrun;

endmodule

// File: doc/pid_controller_mc.md
# pid_controller_mc

Multi-channel, time-multiplexed successor to the single-loop PID controller. It serves CH independent PID loops with one shared multiply/accumulate datapath, sweeping the channels on each prescaler tick. Each loop has a parametrised fixed-point gain format, output saturation and integrator anti-windup. It sits between the sensor/feedback capture logic and the actuator drivers; each channel output is qualified by a one-cycle valid pulse.

## Interface
Parameters:
- DATA_W, 16: setpoint/feedback/output width.
- GAIN_W, 16: Kp/Ki/Kd width, unsigned.
- FRAC_W, 8: fractional bits of the gains; 256 = 1.0 at default.
- CH, 4: number of loops, 1..16.
- ACC_W, 32: signed integrator width.
- PRESC_W, 16: prescaler width.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- enable, in, 1: permits new sweeps.
- integ_clr, in, 1: synchronous clear of all integrators and previous-error registers.
- setpoint, in, CH*DATA_W: unsigned, channel k at [k*DATA_W +: DATA_W].
- feedback, in, CH*DATA_W: unsigned, same packing.
- Kp, Ki, Kd, in, GAIN_W each: shared gains.
- clk_prescaler, in, PRESC_W: tick period is clk_prescaler+1 cycles.
- out_min, out_max, in, DATA_W: signed output clamp limits.
- control_signal, out, CH*DATA_W: signed, saturated, held between updates.
- ctrl_valid, out, CH: one-cycle pulse when channel k is written.
- busy, out, 1: high while a sweep is in progress.
- overrun, out, 1: sticky; set when a tick arrives while busy.

## Operation
- **Prescaler.** The counter runs while enable=1 and holds at 0 otherwise. A tick fires when count==clk_prescaler, and the counter then wraps to 0. clk_prescaler=0 gives a tick every cycle.
- **Sweep start.** A tick while IDLE starts a sweep at ch=0. A tick while busy is dropped and sets overrun, which is cleared only by reset.
- **FSM.** IDLE → ERR → MUL → SUM → WB, then back to ERR with ch+1, or to IDLE after ch=CH-1.
- **ERR.** e = sp[ch] − fb[ch], signed, DATA_W+1 bits. Inputs are sampled in this cycle only.
- **MUL.**
  - p = Kp·e
  - i_next = integ[ch] + Ki·e, saturated to ±(2^(ACC_W-1)−1)
  - d = Kd·(e − e_prev[ch])
- **SUM.** u = (p + i_next + d) >>> FRAC_W (arithmetic shift), then clamp to [out_min, out_max]. If out_min > out_max, u = out_min.
- **WB.**
  - control_signal[ch] = u; pulse ctrl_valid[ch]; e_prev[ch] = e.
  - integ[ch] = i_next, unless anti-windup applies.
  - Anti-windup: if u was clamped high and e>0, or clamped low and e<0, integ[ch] is held.
- **Width rule.** Intermediate sums are wide enough that no wrap occurs before saturation.
- **integ_clr.** Zeroes all integ and e_prev. It wins over a same-cycle WB write to integ/e_prev; the output write still occurs.
- **enable deassert mid-sweep.** The current sweep completes; no new sweep starts.

## Timing
- **Reset values.** control_signal=0, ctrl_valid=0, busy=0, overrun=0, all integ/e_prev=0, FSM=IDLE, counter=0.
- **Latency.** With the tick in cycle T, channel k's WB is in cycle T+4+4k. control_signal[k] and ctrl_valid[k] are visible after that edge.
- **busy.** High from T+1 through the last WB cycle.
- **Sweep length.** 4·CH cycles. clk_prescaler+1 ≥ 4·CH is required for overrun-free operation.
- **Reset mid-sweep.** All state returns to reset values immediately; no partial write persists.

## Structure
- **Package pid_pkg:**
  - state enum (IDLE, ERR, MUL, SUM, WB);
  - a parametrised saturate function (signed in, limits in);
  - the anti-windup predicate.
- **Sub-module pid_prescaler:** counter, tick and enable gating.
- **Top level:** FSM, channel index, integ/e_prev register arrays, shared datapath.

## Test plan
- **Proportional only.** CH=4, Kp=256, Ki=Kd=0, sp0=20, fb0=5, clk_prescaler=15 → control_signal[0]=15 at T+4; ctrl_valid pulses ch0..3 at T+4, T+8, T+12, T+16.
- **Integral only.** Kp=0, Ki=128, e=10 → outputs 5, 10, 15 on successive sweeps.
- **Anti-windup.** Kp=0, Ki=256, out_max=100, e=60 → u=60, then 100 (clamped, integ held at 15360). Then e=−10 → u=50 on the next sweep.
- **Derivative.** Kd=256, Kp=Ki=0, e goes 0→10 → u=10 on that sweep, 0 on the following one.
- **Overrun.** clk_prescaler=5 with CH=4 → overrun=1, one sweep per 4·CH+ window, outputs still correct. A reset mid-sweep clears everything to 0.
- **integ_clr.** Assert integ_clr during a WB with integ≠0 → integ=0 on the next sweep; e.g. Ki=128, e=10 gives u=5.
